// File: rtl/out_drain_pkg.sv
// rtl/out_drain_pkg.sv - shared states and constants for the output BRAM drain sequencer
package out_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE,
    WAIT_LOW
  } drain_state_e;

  function automatic int word_bytes(input int bits);
    return bits / 8;
  endfunction

  localparam int OUT_BITS_DEFAULT = 32;
  localparam int OUT_WORD_BYTES   = word_bytes(OUT_BITS_DEFAULT);
  localparam int FIFO_DEPTH       = 2;

endpackage

// File: rtl/out_drain_fifo2.sv
// rtl/out_drain_fifo2.sv - 2-entry fall-through FIFO carrying {tlast,tdata} from the BRAM read port
// An arriving word is presented the same cycle it lands when the FIFO is empty.
module out_drain_fifo2
  import out_drain_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         store;
  logic         pop;

  assign out_valid = (count_q != 2'd0) || in_valid;
  assign out_data  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : in_data;
  assign pop       = out_ready && (count_q != 2'd0);
  // A word only needs storing if it cannot pass straight through this cycle.
  assign store     = in_valid && !((count_q == 2'd0) && out_ready);
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (store) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, store} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/out_bram_drain_ctrl.sv
// rtl/out_bram_drain_ctrl.sv - drains a filled output BRAM bank to AXI-Stream and releases it
// Optional cycle counters built only when OUT_DRAIN_PERF_EN is defined.
module out_bram_drain_ctrl
  import out_drain_pkg::*;
#(
  parameter int OUT_ADDR_WIDTH = 10,
  parameter int OUT_BITS       = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      done_fill,
  output logic                      t_done_proc,
  input  logic [OUT_ADDR_WIDTH:0]   cfg_words,
  output logic [OUT_ADDR_WIDTH+1:0] bram_addr_a,
  output logic                      bram_en_a,
  input  logic [OUT_BITS-1:0]       bram_rddata_a,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [OUT_BITS-1:0]       m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_drain_cycles
);

  localparam int AW         = OUT_ADDR_WIDTH;
  localparam int BAW        = OUT_ADDR_WIDTH + 2;
  localparam int WORD_BYTES = word_bytes(OUT_BITS);

  drain_state_e         state_q, state_d;
  logic [AW:0]          words_q, words_d;
  logic [AW:0]          rd_idx_q, rd_idx_d;
  logic [BAW-1:0]       addr_q, addr_d;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic [1:0]           fifo_count;
  logic                 fifo_valid;
  logic                 fifo_last;
  logic [OUT_BITS-1:0]  fifo_data;
  logic                 issue;
  logic                 last_issue;
  logic                 accept;
  logic                 start;
  logic [BAW-1:0]       issue_addr;

  assign issue_addr = BAW'(rd_idx_q[AW-1:0]) * BAW'(WORD_BYTES);
  assign last_issue = (rd_idx_q == (words_q - (AW+1)'(1)));
  assign accept     = fifo_valid && m_axis_tready;

  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    rd_idx_d    = rd_idx_q;
    addr_d      = addr_q;
    issue       = 1'b0;
    start       = 1'b0;
    t_done_proc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done_fill) begin
          start    = 1'b1;
          words_d  = cfg_words;
          rd_idx_d = '0;
          state_d  = (cfg_words != '0) ? READ : DONE;
        end
      end
      READ: begin
        // Never request more than the FIFO can absorb, counting the word still in flight.
        if ((({1'b0, inflight_q} + fifo_count) < 2'(FIFO_DEPTH)) && (rd_idx_q < words_q)) begin
          issue    = 1'b1;
          rd_idx_d = rd_idx_q + (AW+1)'(1);
          addr_d   = issue_addr;
        end
        if (accept && fifo_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        t_done_proc = 1'b1;
        state_d     = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!done_fill) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= IDLE;
      words_q         <= '0;
      rd_idx_q        <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      words_q         <= words_d;
      rd_idx_q        <= rd_idx_d;
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
    end
  end

  out_drain_fifo2 #(
    .W(OUT_BITS + 1)
  ) u_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .in_valid (inflight_q),
    .in_data  ({inflight_last_q, bram_rddata_a}),
    .out_valid(fifo_valid),
    .out_data ({fifo_last, fifo_data}),
    .out_ready(m_axis_tready),
    .count    (fifo_count)
  );

  assign bram_en_a     = issue;
  assign bram_addr_a   = issue ? issue_addr : addr_q;
  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = fifo_valid ? fifo_data : '0;
  assign m_axis_tlast  = fifo_valid && fifo_last;
  assign busy          = (state_q != IDLE);

`ifdef OUT_DRAIN_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] drain_q;

  // The cycle that retires tlast is not counted; both counters freeze once READ is left.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_q <= '0;
      drain_q <= '0;
    end else if (start) begin
      stall_q <= '0;
      drain_q <= '0;
    end else if (state_q == READ) begin
      if ((state_d == READ) && (drain_q != 32'hFFFF_FFFF)) begin
        drain_q <= drain_q + 32'd1;
      end
      if (m_axis_tvalid && !m_axis_tready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_drain_cycles = drain_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_drain_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_out_bram_drain_ctrl.sv
// tb/tb_out_bram_drain_ctrl.sv - self-checking bench for out_bram_drain_ctrl
module tb_out_bram_drain_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        done_fill;
  logic        t_done_proc;
  logic [10:0] cfg_words;
  logic [11:0] bram_addr_a;
  logic        bram_en_a;
  logic [31:0] bram_rddata_a = 32'd0;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_drain_cycles;

  logic [31:0] mem [1024];
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    logic        df;
    logic        rdy;
    logic        en;
    logic [11:0] addr;
    logic        tv;
    logic [31:0] td;
    logic        tl;
    logic        dn;
    logic        bz;
  } vec_t;

  vec_t vt[9];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en_a) bram_rddata_a <= mem[bram_addr_a[11:2]];
  end

  out_bram_drain_ctrl #(
    .OUT_ADDR_WIDTH(10),
    .OUT_BITS(32)
  ) dut (
    .aclk             (clk),
    .aresetn          (aresetn),
    .done_fill        (done_fill),
    .t_done_proc      (t_done_proc),
    .cfg_words        (cfg_words),
    .bram_addr_a      (bram_addr_a),
    .bram_en_a        (bram_en_a),
    .bram_rddata_a    (bram_rddata_a),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .busy             (busy),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_drain_cycles(perf_drain_cycles)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // mode 0: tready high; mode 1: tready 1010...; mode 2: tready low on cycles 4..8
  task automatic drain(input int words, input int mode, input bit hold, input int ncyc);
    int   issues = 0;
    int   beats = 0;
    int   dones = 0;
    int   done_cyc = -1;
    int   outst = 0;
    logic stalled = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    cfg_words = 11'(words);
    for (int c = 0; c < ncyc; c++) begin
      done_fill = (c == 0) || hold;
      case (mode)
        1:       m_axis_tready = (c % 2 == 0);
        2:       m_axis_tready = !(c >= 4 && c <= 8);
        default: m_axis_tready = 1'b1;
      endcase
      if (c == 1) cfg_words = 11'd5;
      @(negedge clk);
      if (bram_en_a) begin
        chk("issue_room", 64'(outst < 2), 64'd1);
        chk("issue_addr", 64'(bram_addr_a), 64'(issues * 4));
        issues++;
      end
      if (stalled) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", 64'(m_axis_tdata), 64'(pd));
        chk("hold_last", 64'(m_axis_tlast), 64'(pl));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_data", 64'(m_axis_tdata), 64'(mem[beats[9:0]]));
        chk("beat_last", 64'(m_axis_tlast), 64'(beats == words - 1));
        beats++;
      end
      if (t_done_proc) begin
        dones++;
        done_cyc = c;
      end
      outst   = outst + int'(bram_en_a) - int'(m_axis_tvalid && m_axis_tready);
      stalled = m_axis_tvalid && !m_axis_tready;
      pd      = m_axis_tdata;
      pl      = m_axis_tlast;
      @(posedge clk);
      #1;
    end
    chk("n_issue", 64'(issues), 64'(words));
    chk("n_beats", 64'(beats), 64'(words));
    chk("n_done", 64'(dones), 64'd1);
    if (mode == 0) chk("done_cycle", 64'(done_cyc), 64'((words == 0) ? 1 : words + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int seen_done;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hD00D_0000 + 32'(i);

    vt[0] = '{1'b1, 1'b1, 1'b0, 12'd0,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 12'd0,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 12'd4,  1'b1, 32'hD00D_0000, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 12'd8,  1'b1, 32'hD00D_0001, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b1, 12'd12, 1'b1, 32'hD00D_0002, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b0, 12'd12, 1'b1, 32'hD00D_0003, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 12'd12, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 12'd12, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b1, 1'b0, 12'd12, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};

    aresetn       = 1'b0;
    done_fill     = 1'b0;
    m_axis_tready = 1'b0;
    cfg_words     = 11'd4;
    @(negedge clk);
    chk("rst_en", 64'(bram_en_a), 64'd0);
    chk("rst_addr", 64'(bram_addr_a), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_done", 64'(t_done_proc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perf", 64'({perf_stall_cycles, perf_drain_cycles}), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      done_fill     = vt[i].df;
      m_axis_tready = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_en", i), 64'(bram_en_a), 64'(vt[i].en));
      chk($sformatf("tbl%0d_addr", i), 64'(bram_addr_a), 64'(vt[i].addr));
      chk($sformatf("tbl%0d_tvalid", i), 64'(m_axis_tvalid), 64'(vt[i].tv));
      if (vt[i].tv) chk($sformatf("tbl%0d_tdata", i), 64'(m_axis_tdata), 64'(vt[i].td));
      chk($sformatf("tbl%0d_tlast", i), 64'(m_axis_tlast), 64'(vt[i].tl));
      chk($sformatf("tbl%0d_done", i), 64'(t_done_proc), 64'(vt[i].dn));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(vt[i].bz));
      @(posedge clk);
      #1;
    end

    drain(8, 1, 1'b0, 26);
    drain(0, 0, 1'b0, 6);

    drain(3, 0, 1'b1, 50);
    chk("hold_busy", 64'(busy), 64'd1);
    done_fill = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("low_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    drain(3, 0, 1'b0, 10);

    cfg_words     = 11'd6;
    done_fill     = 1'b1;
    m_axis_tready = 1'b1;
    nb            = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    done_fill = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) nb++;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_beats", 64'(nb), 64'd2);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_en", 64'(bram_en_a), 64'd0);
    chk("mid_rst_addr", 64'(bram_addr_a), 64'd0);
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(t_done_proc), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    aresetn   = 1'b1;
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (t_done_proc || busy || m_axis_tvalid) seen_done++;
      @(posedge clk);
      #1;
    end
    chk("post_rst_quiet", 64'(seen_done), 64'd0);
    drain(6, 0, 1'b0, 12);

    drain(4, 2, 1'b0, 16);
`ifdef OUT_DRAIN_PERF_EN
    chk("perf_stall", 64'(perf_stall_cycles), 64'd5);
    chk("perf_drain", 64'(perf_drain_cycles), 64'd9);
`else
    chk("perf_stall", 64'(perf_stall_cycles), 64'd0);
    chk("perf_drain", 64'(perf_drain_cycles), 64'd0);
`endif

    drain(1024, 0, 1'b0, 1034);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
